// File: rtl/vote_collector_if.sv
// Bundle of the vote_collector data/handshake signals.
// The master side drives the raw buttons and round controls; the slave side (the collector)
// returns the frozen vote vector and round status.
interface vote_collector_if;
   logic [3:0] vote_raw;
   logic       start;
   logic       close;
   logic [3:0] vote_vec;
   logic       done;
   logic       busy;
   logic [2:0] voted_cnt;

   modport master (
      output vote_raw,
      output start,
      output close,
      input  vote_vec,
      input  done,
      input  busy,
      input  voted_cnt
   );

   modport slave (
      input  vote_raw,
      input  start,
      input  close,
      output vote_vec,
      output done,
      output busy,
      output voted_cnt
   );
endinterface

// File: rtl/vote_collector.sv
// vote_collector: debounces four raw voter buttons, runs one voting round per start request,
// latches who voted and presents a frozen 4-bit vote vector to the combinational voter stage.
// Optional feature: define VOTE_TIMEOUT_EN to auto-close a round after ROUND_CYCLES cycles
// in OPEN. Without it the round closes only on close or when all four voters have voted.
module vote_collector #(
   parameter int DEB_CYCLES   = 4,
   parameter int ROUND_CYCLES = 32
) (
   input logic             clk,
   input logic             rst_n,
   vote_collector_if.slave bus
);

   localparam int DCW = $clog2(DEB_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OPEN = 2'b01,
      DONE = 2'b10
   } state_t;

   // Reject parameter values that would break the debounce or round timer.
   if (DEB_CYCLES < 1 || ROUND_CYCLES < 2) begin : g_bad_params
      $error("vote_collector: DEB_CYCLES must be >= 1 and ROUND_CYCLES >= 2");
   end

   state_t                state_q, state_d;
   logic [3:0]            deb_q, deb_d;
   logic [3:0][DCW-1:0]   cnt_q, cnt_d;
   logic [3:0]            latch_q, latch_d;
   logic [3:0]            vote_vec_q, vote_vec_d;
   logic [2:0]            voted_cnt_q, voted_cnt_d;
   logic [3:0]            rise;
   logic                  timeout_hit;
   logic                  close_now;

`ifdef VOTE_TIMEOUT_EN
   localparam int TW = $clog2(ROUND_CYCLES);

   logic [TW-1:0] timer_q, timer_d;

   assign timeout_hit = (timer_q == TW'(ROUND_CYCLES - 1));

   // Round timer: cleared on round entry, counts every OPEN cycle until the round closes.
   always_comb begin
      timer_d = timer_q;
      if (state_q == IDLE && bus.start) begin
         timer_d = '0;
      end else if (state_q == OPEN && !close_now) begin
         timer_d = timer_q + 1'b1;
      end
   end

   // Round timer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Per-bit debounce: a bit flips only after DEB_CYCLES consecutive samples disagreeing with it.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 4; i++) begin
         if (bus.vote_raw[i] != deb_q[i]) begin
            if (cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
               deb_d[i] = ~deb_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
      rise = deb_d & ~deb_q;
   end

   // Round FSM: open on start, collect rising edges, close on request, full vote or timeout.
   always_comb begin
      state_d     = state_q;
      latch_d     = latch_q;
      vote_vec_d  = vote_vec_q;
      voted_cnt_d = voted_cnt_q;
      close_now   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d     = OPEN;
               latch_d     = '0;
               voted_cnt_d = '0;
            end
         end
         OPEN: begin
            latch_d     = latch_q | rise;
            voted_cnt_d = {2'b00, latch_d[0]} + {2'b00, latch_d[1]}
                        + {2'b00, latch_d[2]} + {2'b00, latch_d[3]};
            close_now   = bus.close || (&latch_d) || timeout_hit;
            if (close_now) begin
               state_d    = DONE;
               vote_vec_d = latch_d;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, debounce and vote registers; reset discards any round in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         deb_q       <= '0;
         cnt_q       <= '0;
         latch_q     <= '0;
         vote_vec_q  <= '0;
         voted_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         deb_q       <= deb_d;
         cnt_q       <= cnt_d;
         latch_q     <= latch_d;
         vote_vec_q  <= vote_vec_d;
         voted_cnt_q <= voted_cnt_d;
      end
   end

   assign bus.vote_vec  = vote_vec_q;
   assign bus.done      = (state_q == DONE);
   assign bus.busy      = (state_q == OPEN);
   assign bus.voted_cnt = voted_cnt_q;

endmodule
